// File: rtl/cache_ctrl_lv1_il_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cache_ctrl_lv1_il_seq
// Brief    : L1 instruction-cache controller: tag/valid/LRU state, LV2 fill, flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cache_ctrl_lv1_il_seq #(
   parameter int ASSOC_WID   = 4,
   parameter int NUM_OF_SETS = 64,
   parameter int ADDR_WID    = 32,
   parameter int OFFSET_WID  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_rd,
   input  logic                 cpu_wr,
   input  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1,
   input  logic                 flush,
   input  logic                 lv2_data_valid,
   output logic                 cpu_ready,
   output logic                 cpu_done,
   output logic [ASSOC_WID-1:0] way_sel,
   output logic                 lv2_rd_req,
   output logic [ADDR_WID-1:0]  lv2_addr,
   output logic                 fill_en,
   output logic                 illegal_wr,
   output logic                 busy
);
   localparam int IDX_W = $clog2(NUM_OF_SETS);
   localparam int WAY_W = $clog2(ASSOC_WID);
   localparam int BLK_W = ADDR_WID - OFFSET_WID;
   localparam int TAG_W = BLK_W - IDX_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_MISS   = 3'd2;
   localparam logic [2:0] S_FILL   = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;

   logic [2:0]           r_state;
   logic [2:0]           w_next_state;
   logic                 r_flush_pend;
   logic                 w_flush_pend_nxt;
   logic [IDX_W-1:0]     r_flush_cnt;
   logic [BLK_W-1:0]     r_blk;
   logic [WAY_W-1:0]     r_victim;

   logic [TAG_W-1:0]     r_tag   [NUM_OF_SETS][ASSOC_WID];
   logic [ASSOC_WID-1:0] r_valid [NUM_OF_SETS];
   logic [WAY_W-1:0]     r_age   [NUM_OF_SETS][ASSOC_WID];

   logic                 r_cpu_ready;
   logic                 r_cpu_done;
   logic [ASSOC_WID-1:0] r_way_sel;
   logic                 r_lv2_rd_req;
   logic                 r_fill_en;
   logic                 r_illegal_wr;
   logic                 r_busy;

   logic                 w_cpu_ready_nxt;
   logic                 w_cpu_done_nxt;
   logic [ASSOC_WID-1:0] w_way_sel_nxt;
   logic                 w_lv2_rd_req_nxt;
   logic                 w_fill_en_nxt;
   logic                 w_illegal_wr_nxt;
   logic                 w_busy_nxt;

   logic [IDX_W-1:0]     w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic [ASSOC_WID-1:0] w_match;
   logic                 w_hit;
   logic [WAY_W-1:0]     w_hit_way;
   logic [WAY_W-1:0]     w_victim;
   logic                 w_inv_found;
   logic                 w_lru_en;
   logic [WAY_W-1:0]     w_lru_way;
   logic [WAY_W-1:0]     w_lru_age;
   logic                 w_flush_last;
   logic                 w_unused;

   assign w_idx        = r_blk[IDX_W-1:0];
   assign w_tag        = r_blk[BLK_W-1:IDX_W];
   assign w_flush_last = (r_state == S_FLUSH) && (r_flush_cnt == IDX_W'(NUM_OF_SETS - 1));
   assign w_unused     = ^addr_bus_cpu_lv1[OFFSET_WID-1:0];

   // A hit needs exactly one matching valid way; multiple matches are treated as a miss.
   always_comb begin
      w_match   = '0;
      w_hit_way = '0;
      for (int j = 0; j < ASSOC_WID; j++) begin
         w_match[j] = r_valid[w_idx][j] && (r_tag[w_idx][j] == w_tag);
         if (w_match[j]) begin
            w_hit_way = WAY_W'(j);
         end
      end
      w_hit = (w_match != '0) && ((w_match & (w_match - 1'b1)) == '0);
   end

   always_comb begin
      w_victim    = '0;
      w_inv_found = 1'b0;
      for (int j = 0; j < ASSOC_WID; j++) begin
         if (!w_inv_found && !r_valid[w_idx][j]) begin
            w_victim    = WAY_W'(j);
            w_inv_found = 1'b1;
         end
      end
      if (!w_inv_found) begin
         for (int j = 0; j < ASSOC_WID; j++) begin
            if (r_age[w_idx][j] == WAY_W'(ASSOC_WID - 1)) begin
               w_victim = WAY_W'(j);
            end
         end
      end
   end

   assign w_lru_en  = ((r_state == S_LOOKUP) && w_hit) || (r_state == S_FILL);
   assign w_lru_way = (r_state == S_FILL) ? r_victim : w_hit_way;
   assign w_lru_age = r_age[w_idx][w_lru_way];

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (flush || r_flush_pend) begin
               w_next_state = S_FLUSH;
            end else if (cpu_rd) begin
               w_next_state = S_LOOKUP;
            end
         end
         S_LOOKUP: w_next_state = w_hit ? S_IDLE : S_MISS;
         S_MISS: begin
            if (lv2_data_valid) begin
               w_next_state = S_FILL;
            end
         end
         S_FILL:  w_next_state = S_IDLE;
         S_FLUSH: begin
            if (w_flush_last) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase

      // A flush arriving mid-fetch is remembered and serviced once the fetch ends.
      w_flush_pend_nxt = r_flush_pend;
      if (w_flush_last) begin
         w_flush_pend_nxt = 1'b0;
      end else if (flush && (r_state != S_IDLE) && (r_state != S_FLUSH)) begin
         w_flush_pend_nxt = 1'b1;
      end
   end

   always_comb begin
      w_cpu_done_nxt   = 1'b0;
      w_way_sel_nxt    = '0;
      w_fill_en_nxt    = 1'b0;
      w_illegal_wr_nxt = 1'b0;
      w_lv2_rd_req_nxt = (w_next_state == S_MISS);
      w_cpu_ready_nxt  = (w_next_state == S_IDLE) && !w_flush_pend_nxt;
      w_busy_nxt       = (w_next_state != S_IDLE) || w_flush_pend_nxt;
      case (r_state)
         S_IDLE: begin
            w_illegal_wr_nxt = cpu_wr && !r_flush_pend;
         end
         S_LOOKUP: begin
            if (w_hit) begin
               w_cpu_done_nxt = 1'b1;
               w_way_sel_nxt  = w_match;
            end
         end
         S_FILL: begin
            w_fill_en_nxt  = 1'b1;
            w_cpu_done_nxt = 1'b1;
            w_way_sel_nxt  = {{(ASSOC_WID-1){1'b0}}, 1'b1} << r_victim;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_flush_pend <= 1'b0;
         r_flush_cnt  <= '0;
         r_blk        <= '0;
         r_victim     <= '0;
         r_cpu_ready  <= 1'b0;
         r_cpu_done   <= 1'b0;
         r_way_sel    <= '0;
         r_lv2_rd_req <= 1'b0;
         r_fill_en    <= 1'b0;
         r_illegal_wr <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_flush_pend <= w_flush_pend_nxt;
         if (r_state == S_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
         if ((r_state == S_IDLE) && (w_next_state == S_LOOKUP)) begin
            r_blk <= addr_bus_cpu_lv1[ADDR_WID-1:OFFSET_WID];
         end
         if ((r_state == S_LOOKUP) && !w_hit) begin
            r_victim <= w_victim;
         end
         r_cpu_ready  <= w_cpu_ready_nxt;
         r_cpu_done   <= w_cpu_done_nxt;
         r_way_sel    <= w_way_sel_nxt;
         r_lv2_rd_req <= w_lv2_rd_req_nxt;
         r_fill_en    <= w_fill_en_nxt;
         r_illegal_wr <= w_illegal_wr_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   // Flush clears valid bits only; ages keep their ordering across a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_OF_SETS; s++) begin
            r_valid[s] <= '0;
            for (int j = 0; j < ASSOC_WID; j++) begin
               r_age[s][j] <= WAY_W'(j);
            end
         end
      end else begin
         if (r_state == S_FLUSH) begin
            r_valid[r_flush_cnt] <= '0;
         end
         if (r_state == S_FILL) begin
            r_valid[w_idx][r_victim] <= 1'b1;
         end
         if (w_lru_en) begin
            for (int j = 0; j < ASSOC_WID; j++) begin
               if (WAY_W'(j) == w_lru_way) begin
                  r_age[w_idx][j] <= '0;
               end else if (r_age[w_idx][j] < w_lru_age) begin
                  r_age[w_idx][j] <= r_age[w_idx][j] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_FILL) begin
         r_tag[w_idx][r_victim] <= w_tag;
      end
   end

   assign cpu_ready  = r_cpu_ready;
   assign cpu_done   = r_cpu_done;
   assign way_sel    = r_way_sel;
   assign lv2_rd_req = r_lv2_rd_req;
   assign lv2_addr   = {r_blk, {OFFSET_WID{1'b0}}};
   assign fill_en    = r_fill_en;
   assign illegal_wr = r_illegal_wr;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_lv1_il_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_cache_ctrl_lv1_il_seq
// Brief    : Directed bench with a set/way/age reference model and per-cycle compare.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cache_ctrl_lv1_il_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [31:0] addr_bus = '0;
   logic        flush = 1'b0;
   logic        lv2_data_valid = 1'b0;
   logic        cpu_ready, cpu_done, lv2_rd_req, fill_en, illegal_wr, busy;
   logic [3:0]  way_sel;
   logic [31:0] lv2_addr;

   cache_ctrl_lv1_il_seq dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_rd           (cpu_rd),
      .cpu_wr           (cpu_wr),
      .addr_bus_cpu_lv1 (addr_bus),
      .flush            (flush),
      .lv2_data_valid   (lv2_data_valid),
      .cpu_ready        (cpu_ready),
      .cpu_done         (cpu_done),
      .way_sel          (way_sel),
      .lv2_rd_req       (lv2_rd_req),
      .lv2_addr         (lv2_addr),
      .fill_en          (fill_en),
      .illegal_wr       (illegal_wr),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   bit   chk_en = 1'b0;

   logic        e_ready = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   logic        e_req = 1'b0, e_fill = 1'b0, e_ill = 1'b0;
   logic [3:0]  e_way = '0;
   logic [31:0] e_addr = '0;

   // Reference model: per set, per way tag/valid and LRU age (0 = most recent).
   bit          m_pend = 1'b0;
   bit          m_valid [64][4];
   logic [19:0] m_tag   [64][4];
   int          m_age   [64][4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_ready",  32'(cpu_ready),  32'(e_ready));
         chk("busy",       32'(busy),       32'(e_busy));
         chk("cpu_done",   32'(cpu_done),   32'(e_done));
         chk("lv2_rd_req", 32'(lv2_rd_req), 32'(e_req));
         chk("fill_en",    32'(fill_en),    32'(e_fill));
         chk("illegal_wr", 32'(illegal_wr), 32'(e_ill));
         if (e_done) chk("way_sel",  32'(way_sel), 32'(e_way));
         if (e_req)  chk("lv2_addr", lv2_addr, e_addr);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_clear();
      e_ready = 0; e_busy = 0; e_done = 0; e_req = 0; e_fill = 0; e_ill = 0;
      e_way = '0; e_addr = '0;
   endtask

   task automatic exp_idle();
      exp_clear();
      e_ready = !m_pend;
      e_busy  = m_pend;
   endtask

   task automatic m_reset();
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 4; w++) begin
            m_valid[s][w] = 1'b0;
            m_tag[s][w]   = '0;
            m_age[s][w]   = w;
         end
      m_pend = 1'b0;
   endtask

   task automatic m_touch(input int s, input int w);
      int a;
      a = m_age[s][w];
      for (int j = 0; j < 4; j++)
         if (j == w) m_age[s][j] = 0;
         else if (m_age[s][j] < a) m_age[s][j] = m_age[s][j] + 1;
   endtask

   task automatic m_lookup(input logic [31:0] a, output bit hit, output int way);
      int s, n;
      s = int'(a[11:6]);
      n = 0;
      way = 0;
      for (int w = 0; w < 4; w++)
         if (m_valid[s][w] && m_tag[s][w] == a[31:12]) begin
            n++;
            way = w;
         end
      hit = (n == 1);
      if (!hit) begin
         way = -1;
         for (int w = 3; w >= 0; w--)
            if (!m_valid[s][w]) way = w;
         if (way < 0)
            for (int w = 0; w < 4; w++)
               if (m_age[s][w] == 3) way = w;
      end
   endtask

   // Starts in an IDLE cycle with ready high; ends in the cpu_done cycle.
   task automatic do_read(input logic [31:0] a, input int lat, input bit wr, input bit fl,
                          output bit hit, output int way);
      int s;
      s = int'(a[11:6]);
      cpu_rd = 1; cpu_wr = wr; addr_bus = a;
      tick();
      cpu_rd = 0; cpu_wr = 0; lv2_data_valid = 1;
      m_lookup(a, hit, way);
      exp_clear(); e_busy = 1; e_ill = wr;
      tick();
      lv2_data_valid = 0;
      if (hit) begin
         m_touch(s, way);
         exp_idle(); e_done = 1; e_way = 4'(1 << way);
      end else begin
         for (int k = 0; k < lat; k++) begin
            exp_clear(); e_busy = 1; e_req = 1; e_addr = {a[31:6], 6'b0};
            if (fl && k == 0) flush = 1;
            if (k == lat - 1) lv2_data_valid = 1;
            tick();
            if (fl && k == 0) m_pend = 1;
            flush = 0; lv2_data_valid = 0;
         end
         exp_clear(); e_busy = 1;
         tick();
         m_valid[s][way] = 1'b1;
         m_tag[s][way]   = a[31:12];
         m_touch(s, way);
         exp_idle(); e_done = 1; e_fill = 1; e_way = 4'(1 << way);
      end
   endtask

   task automatic run_flush(input bit pulse, output int busy_cnt);
      busy_cnt = 0;
      if (pulse) flush = 1;
      tick();
      flush = 0;
      for (int k = 0; k < 64; k++) begin
         busy_cnt += int'(busy);
         exp_clear(); e_busy = 1;
         tick();
      end
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_pend = 1'b0;
      exp_idle();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         exp_idle();
      end
   endtask

   bit hit;
   int way, bcnt;

   initial begin
      m_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_cpu_ready",  32'(cpu_ready),  0);
      chk("rst_busy",       32'(busy),       0);
      chk("rst_cpu_done",   32'(cpu_done),   0);
      chk("rst_lv2_rd_req", 32'(lv2_rd_req), 0);
      chk("rst_fill_en",    32'(fill_en),    0);
      chk("rst_illegal_wr", 32'(illegal_wr), 0);
      chk("rst_way_sel",    32'(way_sel),    0);
      chk("rst_lv2_addr",   lv2_addr,        0);
      @(negedge clk);
      rst_n = 1;
      tick();
      exp_idle();
      chk_en = 1;
      idle(2);

      // Write-only request: one illegal_wr pulse, no fetch.
      cpu_wr = 1;
      tick();
      cpu_wr = 0;
      exp_idle(); e_ill = 1;
      lv2_data_valid = 1;
      tick();
      lv2_data_valid = 0;
      exp_idle();
      idle(1);

      do_read(32'h0000_1044, 3, 0, 0, hit, way);
      chk("r037_cold_hit", 32'(hit), 0);
      chk("r037_cold_way", 32'(way), 0);
      do_read(32'h0000_1048, 1, 0, 0, hit, way);
      chk("r037_rehit", 32'(hit), 1);
      chk("r037_rehit_way", 32'(way), 0);

      do_read(32'h0000_2040, 1, 1, 0, hit, way);
      do_read(32'h0000_3040, 2, 0, 0, hit, way);
      do_read(32'h0000_4040, 4, 0, 0, hit, way);
      chk("r038_fill4_way", 32'(way), 3);
      do_read(32'h0000_1040, 1, 0, 0, hit, way);
      chk("r038_tag1_hit", 32'(hit), 1);
      do_read(32'h0000_5040, 2, 0, 0, hit, way);
      chk("r038_victim_way", 32'(way), 1);
      idle(1);

      do_read(32'hABCD_E7C4, 2, 0, 0, hit, way);
      chk("set31_cold_way", 32'(way), 0);
      do_read(32'hABCD_E7FC, 1, 0, 0, hit, way);
      chk("set31_hit", 32'(hit), 1);
      idle(1);

      run_flush(1, bcnt);
      chk("r039_busy_cycles", 32'(bcnt), 64);

      // Flush during a miss: fill finishes, then the flush runs without ready.
      do_read(32'h0000_1044, 2, 0, 1, hit, way);
      chk("r039_after_flush_miss", 32'(hit), 0);
      run_flush(0, bcnt);
      chk("r040_busy_cycles", 32'(bcnt), 64);
      do_read(32'h0000_1044, 1, 0, 0, hit, way);
      chk("r040_flushed_miss", 32'(hit), 0);
      idle(1);

      do_read(32'h0000_7044, 1, 0, 0, hit, way);
      idle(1);
      cpu_rd = 1; addr_bus = 32'h0000_8044;
      tick();
      cpu_rd = 0;
      exp_clear(); e_busy = 1;
      tick();
      exp_clear(); e_busy = 1; e_req = 1; e_addr = 32'h0000_8040;
      @(negedge clk);
      #1;
      chk_en = 0;
      rst_n = 0;
      #1;
      chk("r042_req_drop",  32'(lv2_rd_req), 0);
      chk("r042_busy_drop", 32'(busy), 0);
      m_reset();
      tick();
      @(negedge clk);
      rst_n = 1;
      tick();
      exp_idle();
      chk_en = 1;
      do_read(32'h0000_7044, 2, 0, 0, hit, way);
      chk("r042_prior_miss", 32'(hit), 0);
      do_read(32'h0000_8044, 1, 0, 0, hit, way);
      chk("r042_second_miss", 32'(hit), 0);
      idle(2);

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
`default_nettype wire
